// File: rtl/fft_output_serializer_if.sv
// Frame-in / bin-out bundle for the FFT output serializer.
// slave = serializer side, master = FFT/downstream side.
interface fft_output_serializer_if #(
  parameter int WIDTH = 16
);
  logic                   in_valid;
  logic [WIDTH*32-1:0]    in_real;
  logic [WIDTH*32-1:0]    in_imag;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_real;
  logic [WIDTH-1:0]       out_imag;
  logic [4:0]             out_index;
  logic                   out_last;
  logic [2*WIDTH-1:0]     out_power;
  logic                   overflow;

  modport slave (
    input  in_valid, in_real, in_imag, out_ready,
    output in_ready, out_valid, out_real, out_imag, out_index, out_last,
           out_power, overflow
  );

  modport master (
    output in_valid, in_real, in_imag, out_ready,
    input  in_ready, out_valid, out_real, out_imag, out_index, out_last,
           out_power, overflow
  );
endinterface

// File: rtl/fft_output_serializer.sv
// Captures a 32-bin FFT frame and streams it one bin per transfer with |X|^2.
// Latency 1 cycle from capture to bin 0; out_ready=0 holds the current bin.
module fft_output_serializer #(
  parameter int WIDTH         = 16,
  parameter int FRACTION_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fft_output_serializer_if.slave bus
);
  localparam int NBINS = 32;

  // Fractional position only sets the scaling of out_power; it must lie within a component.
  if (FRACTION_BITS < 0 || FRACTION_BITS >= WIDTH) begin : g_bad_frac
    $error("FRACTION_BITS must be in [0, WIDTH-1]");
  end

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [4:0]       r_index;
  logic [4:0]       w_index_nxt;
  logic             w_capture;
  logic             r_overflow;
  logic [WIDTH-1:0] r_buf_re [NBINS];
  logic [WIDTH-1:0] r_buf_im [NBINS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_index <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_index <= w_index_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_capture   = 1'b1;
          w_index_nxt = 5'd0;
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (bus.out_ready) begin
          if (r_index == 5'd31) begin
            w_index_nxt = 5'd0;
            w_state_nxt = IDLE;
          end else begin
            w_index_nxt = r_index + 5'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Frame storage is data only; no reset needed.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int k = 0; k < NBINS; k++) begin
        r_buf_re[k] <= bus.in_real[k*WIDTH +: WIDTH];
        r_buf_im[k] <= bus.in_imag[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (bus.in_valid && (r_state == STREAM)) begin
      r_overflow <= 1'b1;
    end
  end

  logic                   w_streaming;
  logic [WIDTH-1:0]       w_cur_re;
  logic [WIDTH-1:0]       w_cur_im;
  logic signed [2*WIDTH-1:0] w_re_ext;
  logic signed [2*WIDTH-1:0] w_im_ext;
  logic signed [2*WIDTH-1:0] w_sq_re;
  logic signed [2*WIDTH-1:0] w_sq_im;

  assign w_streaming = (r_state == STREAM);

  // Gating with the state keeps outputs at zero while idle or in reset.
  assign w_cur_re = w_streaming ? r_buf_re[r_index] : '0;
  assign w_cur_im = w_streaming ? r_buf_im[r_index] : '0;

  assign w_re_ext = {{WIDTH{w_cur_re[WIDTH-1]}}, w_cur_re};
  assign w_im_ext = {{WIDTH{w_cur_im[WIDTH-1]}}, w_cur_im};
  assign w_sq_re  = w_re_ext * w_re_ext;
  assign w_sq_im  = w_im_ext * w_im_ext;

  assign bus.in_ready  = !w_streaming;
  assign bus.out_valid = w_streaming;
  assign bus.out_real  = w_cur_re;
  assign bus.out_imag  = w_cur_im;
  assign bus.out_index = r_index;
  assign bus.out_last  = w_streaming && (r_index == 5'd31);
  // Each square is below 2^(2*WIDTH-1), so the unsigned sum cannot wrap.
  assign bus.out_power = $unsigned(w_sq_re) + $unsigned(w_sq_im);
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_fft_output_serializer.sv
// Bench for fft_output_serializer: queue-of-pending-bins reference model,
// a table of power vectors, and hand-written corner-case sequences.
module tb_fft_output_serializer;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fft_output_serializer_if #(.WIDTH(W)) bus();

  fft_output_serializer #(.WIDTH(W), .FRACTION_BITS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int re;
    int im;
    int idx;
  } bin_t;

  typedef struct {
    int          re;
    int          im;
    logic [31:0] pw;
  } pvec_t;

  bin_t q[$];
  logic exp_ovf;
  int   checks = 0;
  int   errors = 0;
  int   xfers  = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic set_bin(int k, int re, int im);
    logic [W-1:0] r16, i16;
    r16 = re[W-1:0];
    i16 = im[W-1:0];
    bus.in_real[k*W +: W] = r16;
    bus.in_imag[k*W +: W] = i16;
  endtask

  task automatic set_frame_rand();
    for (int k = 0; k < 32; k++) set_bin(k, $urandom, $urandom);
  endtask

  task automatic check_outputs();
    longint p;
    chk("in_ready", 64'(bus.in_ready), 64'(q.size() == 0));
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    chk("overflow", 64'(bus.overflow), 64'(exp_ovf));
    if (q.size() != 0) begin
      p = longint'(q[0].re) * q[0].re + longint'(q[0].im) * q[0].im;
      chk("out_real", 64'($signed(bus.out_real)), 64'(q[0].re));
      chk("out_imag", 64'($signed(bus.out_imag)), 64'(q[0].im));
      chk("out_index", 64'(bus.out_index), 64'(q[0].idx));
      chk("out_last", 64'(bus.out_last), 64'(q[0].idx == 31));
      chk("out_power", 64'(bus.out_power), 64'(p));
    end
  endtask

  // Reference: a frame is a list of 32 pending bins; it can only enter when the list is empty.
  task automatic model_edge(logic v, logic r);
    bit busy;
    logic signed [W-1:0] re, im;
    busy = (q.size() != 0);
    if (busy && v) exp_ovf = 1'b1;
    if (busy && r) begin
      void'(q.pop_front());
      xfers++;
    end
    if (!busy && v) begin
      for (int k = 0; k < 32; k++) begin
        re = bus.in_real[k*W +: W];
        im = bus.in_imag[k*W +: W];
        q.push_back('{re: int'(re), im: int'(im), idx: k});
      end
    end
  endtask

  task automatic step(logic v, logic r);
    bus.in_valid  = v;
    bus.out_ready = r;
    check_outputs();
    model_edge(v, r);
    @(negedge clk);
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      step(1'b0, 1'b1);
      n++;
    end
    chk("drain_done", 64'(q.size()), 64'd0);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_out_index", 64'(bus.out_index), 64'd0);
    chk("rst_out_real", 64'(bus.out_real), 64'd0);
    chk("rst_out_imag", 64'(bus.out_imag), 64'd0);
    chk("rst_out_power", 64'(bus.out_power), 64'd0);
    q.delete();
    exp_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pvec_t tbl[6];
    int    x0;

    tbl[0] = '{re: -32768, im: -32768, pw: 32'h8000_0000};
    tbl[1] = '{re:  32767, im:  32767, pw: 32'h7FFE_0002};
    tbl[2] = '{re:  32767, im: -32768, pw: 32'h7FFF_0001};
    tbl[3] = '{re:    768, im:   -768, pw: 32'h0012_0000};
    tbl[4] = '{re:     -1, im:      1, pw: 32'h0000_0002};
    tbl[5] = '{re:      0, im:      0, pw: 32'h0000_0000};

    rst_n = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_real   = '0;
    bus.in_imag   = '0;
    exp_ovf = 1'b0;
    #2;
    do_reset();

    // Ramp frame with continuous out_ready
    for (int k = 0; k < 32; k++) set_bin(k, k * 256, -k * 256);
    step(1'b1, 1'b1);
    for (int i = 0; i < 32; i++) begin
      chk("basic_index", 64'(bus.out_index), 64'(i));
      if (i == 5) chk("basic_real5", 64'(bus.out_real), 64'h0500);
      if (i == 3) chk("basic_power3", 64'(bus.out_power), 64'(18 << 16));
      step(1'b0, 1'b1);
    end
    chk("basic_ready_after", 64'(bus.in_ready), 64'd1);
    chk("basic_valid_after", 64'(bus.out_valid), 64'd0);

    // Backpressure pattern 1,0,0 repeating
    set_frame_rand();
    step(1'b1, 1'b1);
    x0 = xfers;
    for (int i = 0; i < 200 && q.size() != 0; i++) step(1'b0, (i % 3) == 0);
    chk("bp_transfers", 64'(xfers - x0), 64'd32);

    // Power vectors applied on bin 0
    for (int i = 0; i < 6; i++) begin
      set_frame_rand();
      set_bin(0, tbl[i].re, tbl[i].im);
      step(1'b1, 1'b1);
      chk("tbl_power", 64'(bus.out_power), 64'(tbl[i].pw));
      drain(40);
    end

    // Overflow pulse at index 10; the stream must continue from the original frame
    set_frame_rand();
    step(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    chk("ovf_at_index", 64'(bus.out_index), 64'd10);
    set_frame_rand();
    step(1'b1, 1'b1);
    drain(40);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("ovf_sticky", 64'(bus.overflow), 64'd1);

    // Reset at index 7 abandons the frame
    set_frame_rand();
    step(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
    chk("mid_rst_index", 64'(bus.out_index), 64'd7);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    chk("mid_rst_idle", 64'(bus.out_valid), 64'd0);

    // in_valid held high across two frames
    x0 = xfers;
    for (int i = 0; i < 66; i++) begin
      set_frame_rand();
      step(1'b1, 1'b1);
    end
    chk("held_transfers", 64'(xfers - x0), 64'd64);
    chk("held_overflow", 64'(bus.overflow), 64'd1);
    step(1'b0, 1'b1);

    // Random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_frame_rand();
      step(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
    end
    drain(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
